// File: rtl/tba_pkg.sv
// Shared types and helpers for the tri-state bus arbiter (tristate_bus_arb and rr_pick).
package tba_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StTurn
    } tba_state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned owner_w(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping modulo N_CH.
module rr_pick
    import tba_pkg::*;
#(
    parameter int unsigned N_CH = 4,
    parameter int unsigned OW   = owner_w(N_CH)
) (
    input  logic [N_CH-1:0] req_i,
    input  logic [OW-1:0]   ptr_i,
    output logic            valid_o,
    output logic [OW-1:0]   index_o,
    output logic [N_CH-1:0] onehot_o
);

    logic [OW-1:0] cand;

    always_comb begin
        valid_o  = 1'b0;
        index_o  = '0;
        onehot_o = '0;
        cand     = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            cand = OW'((32'(ptr_i) + i) % N_CH);
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                index_o = cand;
            end
        end
        if (valid_o) begin
            onehot_o[index_o] = 1'b1;
        end
    end

endmodule

// File: rtl/tristate_bus_arb.sv
// Round-robin owner of a shared tri-state bus with enforced high-Z turnaround between owners.
// Optional TBA_HOLD_LIMIT_EN caps each grant at MAX_HOLD consecutive drive cycles.
module tristate_bus_arb
    import tba_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned TURN_CYCLES = 1,
    parameter int unsigned MAX_HOLD    = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_CH-1:0]           req_i,
    input  logic [N_CH*WIDTH-1:0]     din_i,
    output logic [N_CH-1:0]           gnt_o,
    output logic [owner_w(N_CH)-1:0]  owner_o,
    output logic                      bus_oe_o,
    output wire logic [WIDTH-1:0]     dout_o
);

    localparam int unsigned OW = owner_w(N_CH);
    localparam int unsigned TW = owner_w(TURN_CYCLES);

    tba_state_t      state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [N_CH-1:0] gnt_q, gnt_d;
    logic [TW-1:0]   turn_cnt_q, turn_cnt_d;

    logic            pick_valid;
    logic [OW-1:0]   pick_idx;
    logic [N_CH-1:0] pick_onehot;
    logic            turn_last;
    logic            hold_expired;
    logic            drive_release;
    logic [WIDTH-1:0] din_sel;

    rr_pick #(
        .N_CH (N_CH),
        .OW   (OW)
    ) u_rr_pick (
        .req_i    (req_i),
        .ptr_i    (rr_ptr_q),
        .valid_o  (pick_valid),
        .index_o  (pick_idx),
        .onehot_o (pick_onehot)
    );

    assign turn_last     = (turn_cnt_q == TW'(TURN_CYCLES - 1));
    assign drive_release = !req_i[owner_q] || hold_expired;

`ifdef TBA_HOLD_LIMIT_EN
    localparam int unsigned HW = owner_w(MAX_HOLD);

    logic [HW-1:0] hold_cnt_q, hold_cnt_d;

    assign hold_expired = (hold_cnt_q == HW'(MAX_HOLD - 1));

    always_comb begin
        hold_cnt_d = '0;
        if (state_q == StDrive && !drive_release) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    assign hold_expired = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            turn_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            turn_cnt_q <= turn_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_d      = gnt_q;
        turn_cnt_d = turn_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d = StDrive;
                    owner_d = pick_idx;
                    gnt_d   = pick_onehot;
                end
            end
            StDrive: begin
                // No preemption: only the owner's own request (or the hold limit) ends a grant.
                if (drive_release) begin
                    state_d    = StTurn;
                    gnt_d      = '0;
                    turn_cnt_d = '0;
                    rr_ptr_d   = (owner_q == OW'(N_CH - 1)) ? '0 : owner_q + 1'b1;
                end
            end
            StTurn: begin
                if (turn_last) begin
                    turn_cnt_d = '0;
                    if (pick_valid) begin
                        state_d = StDrive;
                        owner_d = pick_idx;
                        gnt_d   = pick_onehot;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    turn_cnt_d = turn_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    // Outputs; the enable decodes from the async-reset state flop so reset floats the bus at once.
    always_comb begin
        bus_oe_o = (state_q == StDrive);
        gnt_o    = gnt_q;
        owner_o  = owner_q;
        din_sel  = din_i[owner_q*WIDTH +: WIDTH];
    end

    assign dout_o = bus_oe_o ? din_sel : {WIDTH{1'bz}};

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert ($onehot0(gnt_q));
            assert ((state_q == StDrive) == (gnt_q != '0));
            assert (N_CH >= 2 && TURN_CYCLES >= 1 && MAX_HOLD >= 1);
        end
    end

endmodule

// File: tb/tb_tristate_bus_arb.sv
// Self-checking bench for tristate_bus_arb: vector table with scoreboard plus multi-cycle sequences.
module tb_tristate_bus_arb;

    localparam logic [31:0] D  = 32'hD4A5_2211;
    localparam logic [31:0] D2 = 32'hD45A_2211;
    localparam int NV = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, req3;
    logic [31:0] din;
    logic [3:0]  gnt, gnt3;
    logic [1:0]  owner, owner3;
    logic        oe, oe3;
    wire  [7:0]  dout, dout3;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] din;
        logic [3:0]  gnt;
        logic        oe;
        logic [1:0]  owner;
        logic [7:0]  dout;
    } vec_t;

    vec_t vecs[NV];
    vec_t sb[$];
    vec_t e;
    int   exp_order[$];

    always #5 clk = ~clk;

    tristate_bus_arb #(
        .N_CH(4), .WIDTH(8), .TURN_CYCLES(1), .MAX_HOLD(4)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .din_i(din),
        .gnt_o(gnt), .owner_o(owner), .bus_oe_o(oe), .dout_o(dout)
    );

    tristate_bus_arb #(
        .N_CH(4), .WIDTH(8), .TURN_CYCLES(3), .MAX_HOLD(4)
    ) u_dut3 (
        .clk_i(clk), .rst_i(rst), .req_i(req3), .din_i(din),
        .gnt_o(gnt3), .owner_o(owner3), .bus_oe_o(oe3), .dout_o(dout3)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int grants, gap, dcnt, cur, zcnt, held;
        logic prev_oe;
        logic [3:0] exp_g;

        // req, din, exp gnt, exp oe, exp owner, exp dout
        vecs[0]  = '{4'b0100, D,  4'b0100, 1'b1, 2'd2, 8'hA5};
        vecs[1]  = '{4'b0100, D2, 4'b0100, 1'b1, 2'd2, 8'h5A};
        vecs[2]  = '{4'b0000, D,  4'b0000, 1'b0, 2'd2, 8'h00};
        vecs[3]  = '{4'b0000, D,  4'b0000, 1'b0, 2'd2, 8'h00};
        vecs[4]  = '{4'b0011, D,  4'b0001, 1'b1, 2'd0, 8'h11};
        vecs[5]  = '{4'b0010, D,  4'b0000, 1'b0, 2'd0, 8'h00};
        vecs[6]  = '{4'b0010, D,  4'b0010, 1'b1, 2'd1, 8'h22};
        vecs[7]  = '{4'b0000, D,  4'b0000, 1'b0, 2'd1, 8'h00};
        vecs[8]  = '{4'b0000, D,  4'b0000, 1'b0, 2'd1, 8'h00};
        vecs[9]  = '{4'b0001, D,  4'b0001, 1'b1, 2'd0, 8'h11};
        vecs[10] = '{4'b1101, D,  4'b0001, 1'b1, 2'd0, 8'h11};
        vecs[11] = '{4'b1100, D,  4'b0000, 1'b0, 2'd0, 8'h00};
        vecs[12] = '{4'b1100, D,  4'b0100, 1'b1, 2'd2, 8'hA5};
        vecs[13] = '{4'b0000, D,  4'b0000, 1'b0, 2'd2, 8'h00};
        vecs[14] = '{4'b0000, D,  4'b0000, 1'b0, 2'd2, 8'h00};

        rst = 1'b1; req = '0; req3 = '0; din = D;
        #1;
        check("reset_gnt", 32'(gnt), 32'h0);
        check("reset_oe", 32'(oe), 32'h0);
        check("reset_owner", 32'(owner), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            req = vecs[i].req;
            din = vecs[i].din;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(e.gnt));
            check($sformatf("vec%0d_oe", i), 32'(oe), 32'(e.oe));
            check($sformatf("vec%0d_owner", i), 32'(owner), 32'(e.owner));
            if (e.oe) check($sformatf("vec%0d_dout", i), 32'(dout), 32'(e.dout));
        end
        check("dut3_idle_oe", 32'(oe3), 32'h0);

        // Async reset in the middle of a drive
        @(negedge clk);
        req = 4'b1000;
        @(posedge clk);
        #1;
        check("rst_pre_oe", 32'(oe), 32'h1);
        check("rst_pre_gnt", 32'(gnt), 32'h8);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_oe", 32'(oe), 32'h0);
        check("rst_async_gnt", 32'(gnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        @(posedge clk);
        #1;
        check("rst_post_gnt", 32'(gnt), 32'h0);
        check("rst_post_owner", 32'(owner), 32'h0);
        check("rst_post_oe", 32'(oe), 32'h0);

        // Round robin: all request, each owner drops after 3 drive cycles and reasserts
        exp_order = '{0, 1, 2, 3, 0};
        grants = 0; gap = 0; dcnt = 0; cur = 0; prev_oe = 1'b0;
        @(negedge clk);
        req = 4'b1111;
        for (int cyc = 0; cyc < 60 && grants < 5; cyc++) begin
            @(negedge clk);
            if (oe) begin
                if (!prev_oe) begin
                    grants++;
                    cur = exp_order.pop_front();
                    exp_g = 4'(1 << cur);
                    check("rr_owner", 32'(owner), 32'(cur));
                    check("rr_gnt", 32'(gnt), 32'(exp_g));
                    check("rr_dout", 32'(dout), 32'(din[cur*8 +: 8]));
                    if (grants > 1) check("rr_gap", 32'(gap), 32'd1);
                    gap = 0;
                    dcnt = 0;
                end
                dcnt++;
                if (dcnt == 3) req[cur] = 1'b0;
            end else begin
                gap++;
                req = 4'b1111;
            end
            prev_oe = oe;
        end
        check("rr_grants", 32'(grants), 32'd5);
        req = '0;
        repeat (3) @(negedge clk);

        // Turnaround of 3 cycles: ch1 releases while ch2 waits
        req3 = 4'b0110;
        @(posedge clk);
        #1;
        check("turn3_first_gnt", 32'(gnt3), 32'h2);
        @(negedge clk);
        req3 = 4'b0100;
        zcnt = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (oe3) break;
            zcnt++;
        end
        check("turn3_gap", 32'(zcnt), 32'd3);
        check("turn3_gnt", 32'(gnt3), 32'h4);
        check("turn3_owner", 32'(owner3), 32'd2);
        check("turn3_dout", 32'(dout3), 32'hA5);
        req3 = '0;

        // Hold limit
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0011;
`ifdef TBA_HOLD_LIMIT_EN
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("hold_c0_%0d", i), 32'(gnt), 32'h1);
        end
        @(negedge clk);
        check("hold_turn_oe", 32'(oe), 32'h0);
        @(negedge clk);
        check("hold_c1_gnt", 32'(gnt), 32'h2);
`else
        held = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt == 4'b0001 && oe) held++;
        end
        check("hold_unlimited", 32'(held), 32'd20);
`endif
        req = '0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
